// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: mode and state encodings shared by the pattern sequencer.
package pattern_seq_pkg;
  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/pattern_sequencer_step_timer.sv
// step_timer: prescaler that wraps at DIV-1 while enabled and freezes otherwise.
module step_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic zero
);
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);
  logic [31:0] count_q;
  assign tick = en && (count_q == DIV_M1);
  assign zero = (count_q == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (clr) count_q <= '0;
    else if (en) count_q <= tick ? '0 : count_q + 32'd1;
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: steps a ROM address at a fixed refresh rate and registers the
// returned pattern word; supports loop, one-shot, ping-pong and hold modes.
module pattern_sequencer import pattern_seq_pkg::*; #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 6,
  parameter int ROM_DEPTH       = 36,
  parameter int CLOCK_FREQUENCY = 200000000,
  parameter int REFRESH_RATE    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  flag,
  output logic                  busy,
  output logic                  done
);
  localparam int DIV = CLOCK_FREQUENCY / REFRESH_RATE;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ROM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  if (DIV < 2) begin : g_bad_div
    $error("pattern_sequencer: DIV must be >= 2");
  end
  if (ROM_DEPTH < 1 || ROM_DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("pattern_sequencer: ROM_DEPTH out of range for ADDR_WIDTH");
  end
  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    dir_q, dir_d;
  logic                    busy_q, done_q, v1_q, vld_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    run, tick, zero, at_last, at_zero;
  assign run     = (state_q == ST_RUN) && en;
  assign at_last = (addr_q == LAST);
  assign at_zero = (addr_q == '0);
  step_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (start || stop),
    .tick (tick),
    .zero (zero)
  );
  // dir_q: 0 = counting up, 1 = counting down (ping-pong only)
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else if (start) begin
      state_d = ST_RUN;
      addr_d  = '0;
      dir_d   = 1'b0;
      mode_d  = mode_e'(mode);
    end else if (tick) begin
      unique case (mode_q)
        MODE_LOOP: addr_d = at_last ? '0 : addr_q + ONE;
        MODE_ONESHOT: begin
          addr_d  = at_last ? addr_q : addr_q + ONE;
          state_d = at_last ? ST_DONE : ST_RUN;
        end
        MODE_PINGPONG: if (ROM_DEPTH > 1) begin
          addr_d = (dir_q ? at_zero : !at_last) ? addr_q + ONE : addr_q - ONE;
          dir_d  = dir_q ? !at_zero : at_last;
        end
        MODE_HOLD: addr_d = addr_q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LOOP;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      v1_q    <= (state_q != ST_IDLE);
      vld_q   <= v1_q;
      dout_q  <= v1_q ? rom_data : dout_q;
    end
  assign rom_addr   = addr_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign flag       = run && zero;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed checks with DIV=4, ROM_DEPTH=4, ROM data = addr + 0xA0.
module tb_pattern_sequencer;
  localparam int DW = 16;
  localparam int AW = 6;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] dout;
  logic          dout_valid, flag, busy, done;
  int            total = 0;
  int            bad = 0;
  int            pp_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_data <= DW'(rom_addr) + 16'hA0;
  pattern_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_DEPTH(4),
    .CLOCK_FREQUENCY(40), .REFRESH_RATE(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .dout(dout), .dout_valid(dout_valid),
    .flag(flag), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [1:0] m);
    start = 1'b1;
    mode = m;
    step(1);
    start = 1'b0;
  endtask
  initial begin
    step(2);
    check("rst_addr", rom_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_vld", dout_valid, 0);
    check("rst_flag", flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step(3);
    check("idle_flag", flag, 0);
    check("idle_addr", rom_addr, 0);
    pulse_start(2'd0);
    for (int c = 0; c < 24; c++) begin
      check("loop_addr", rom_addr, (c / 4) % 4);
      check("loop_flag", flag, 32'(c % 4 == 0));
      check("loop_vld", dout_valid, 32'(c >= 2));
      check("loop_busy", busy, 1);
      if (c >= 2) check("loop_dout", dout, 32'hA0 + ((c - 2) / 4) % 4);
      step(1);
    end
    pulse_start(2'd1);
    for (int c = 0; c < 21; c++) begin
      check("os_addr", rom_addr, c < 16 ? (c / 4) : 3);
      check("os_done", done, 32'(c >= 16));
      check("os_busy", busy, 32'(c < 16));
      check("os_flag", flag, 32'(c < 16 && c % 4 == 0));
      step(1);
    end
    pulse_start(2'd2);
    for (int c = 0; c < 32; c++) begin
      check("pp_addr", rom_addr, pp_seq[c / 4]);
      step(1);
    end
    pulse_start(2'd0);
    step(2);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("pause_addr", rom_addr, 0);
      check("pause_flag", flag, 0);
    end
    en = 1'b1;
    check("resume_flag0", flag, 0);
    step(1);
    check("resume_addr1", rom_addr, 0);
    step(1);
    check("resume_addr2", rom_addr, 1);
    check("resume_flag2", flag, 1);
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    check("conf_busy", busy, 0);
    check("conf_addr", rom_addr, 0);
    check("conf_flag", flag, 0);
    check("conf_vld0", dout_valid, 1);
    step(1);
    check("conf_vld1", dout_valid, 1);
    step(1);
    check("conf_vld2", dout_valid, 0);
    check("conf_dout2", dout, 16'hA1);
    step(1);
    check("conf_dout3", dout, 16'hA1);
    pulse_start(2'd0);
    step(8);
    check("mid_addr_pre", rom_addr, 2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("mid_addr", rom_addr, 0);
    check("mid_busy", busy, 1);
    pulse_start(2'd3);
    for (int c = 0; c < 16; c++) begin
      check("hold_addr", rom_addr, 0);
      check("hold_flag", flag, 32'(c % 4 == 0));
      step(1);
    end
    pulse_start(2'd0);
    step(6);
    check("pre_rst_addr", rom_addr, 1);
    check("pre_rst_dout", dout, 16'hA1);
    rst = 1'b1;
    #1;
    check("arst_addr", rom_addr, 0);
    check("arst_dout", dout, 0);
    check("arst_vld", dout_valid, 0);
    check("arst_flag", flag, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    step(1);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
